// File: rtl/gpio_pad_input_filter_if.sv
// Event handshake between the pad input filter (producer) and the GPIO event unit (consumer).
interface gpio_pad_input_filter_if #(
   parameter int unsigned IDX_W = 4
) ();
   logic             evt_valid_o;
   logic             evt_ready_i;
   logic [IDX_W-1:0] evt_idx_o;
   logic             evt_level_o;

   modport master (output evt_valid_o, evt_idx_o, evt_level_o, input evt_ready_i);
   modport slave  (input evt_valid_o, evt_idx_o, evt_level_o, output evt_ready_i);
endinterface

// File: rtl/gpio_pad_input_filter.sv
// Pad receive conditioner: synchronise, deglitch and edge-detect each pad input, then queue
// {pin, level} change events for the GPIO event unit.
module gpio_pad_input_filter #(
   parameter int unsigned NUM_GPIO    = 9,
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned CNT_WIDTH   = 8,
   parameter int unsigned FIFO_DEPTH  = 4,
   parameter int unsigned IDX_W       = $clog2(NUM_GPIO)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NUM_GPIO-1:0]     pad_c_i,
   input  logic [NUM_GPIO-1:0]     ie_i,
   input  logic [NUM_GPIO-1:0]     filt_en_i,
   input  logic [CNT_WIDTH-1:0]    filt_len_i,
   output logic [NUM_GPIO-1:0]     gpio_in_o,
   output logic [NUM_GPIO-1:0]     rise_o,
   output logic [NUM_GPIO-1:0]     fall_o,
   output logic [NUM_GPIO-1:0]     overrun_o,
   input  logic                    clr_overrun_i,
   gpio_pad_input_filter_if.master evt
);
   localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
   localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   logic [SYNC_STAGES-1:0][NUM_GPIO-1:0] r_sync;
   logic [NUM_GPIO-1:0]                  r_stable, r_rise, r_fall, r_pend, r_overrun;
   logic [NUM_GPIO-1:0][CNT_WIDTH-1:0]   r_cnt;
   logic [FIFO_DEPTH-1:0][IDX_W:0]       r_mem;
   logic [PTR_W-1:0]                     r_wr_ptr, r_rd_ptr;
   logic [CNT_W-1:0]                     r_count;

   logic [NUM_GPIO-1:0]                  w_sync, w_stable_d, w_edge, w_sel;
   logic [NUM_GPIO-1:0]                  w_pend_d, w_overrun_d;
   logic [NUM_GPIO-1:0][CNT_WIDTH-1:0]   w_cnt_d;
   logic [IDX_W-1:0]                     w_push_idx;
   logic                                 w_any_pend, w_push, w_pop;
   logic [CNT_W-1:0]                     w_count_d;

   assign w_sync = r_sync[SYNC_STAGES-1];

   // >= rather than == so a mid-count shrink of filt_len_i can never let the counter wrap.
   always_comb begin
      w_stable_d = r_stable;
      w_cnt_d    = r_cnt;
      for (int i = 0; i < NUM_GPIO; i++) begin
         if (ie_i[i]) begin
            if (!filt_en_i[i]) begin
               w_stable_d[i] = w_sync[i];
               w_cnt_d[i]    = '0;
            end else if (w_sync[i] == r_stable[i]) begin
               w_cnt_d[i] = '0;
            end else if (r_cnt[i] >= filt_len_i) begin
               w_stable_d[i] = w_sync[i];
               w_cnt_d[i]    = '0;
            end else begin
               w_cnt_d[i] = r_cnt[i] + 1'b1;
            end
         end
      end
   end

   always_comb begin
      w_sel      = '0;
      w_push_idx = '0;
      w_any_pend = 1'b0;
      for (int i = 0; i < NUM_GPIO; i++) begin
         if (r_pend[i] && !w_any_pend) begin
            w_any_pend    = 1'b1;
            w_sel[i]      = 1'b1;
            w_push_idx    = IDX_W'(i);
         end
      end
      w_push = w_any_pend && (r_count < DEPTH_C);
      if (!w_push) w_sel = '0;
      w_pop  = evt.evt_valid_o && evt.evt_ready_i;
      w_edge = r_rise | r_fall;
      // An edge coinciding with its own push re-arms pend without counting as lost.
      w_pend_d    = (r_pend & ~w_sel) | w_edge;
      w_overrun_d = (r_overrun & ~{NUM_GPIO{clr_overrun_i}}) | (w_edge & r_pend & ~w_sel);
      w_count_d   = r_count;
      if (w_push && !w_pop) w_count_d = r_count + 1'b1;
      else if (!w_push && w_pop) w_count_d = r_count - 1'b1;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sync    <= '0;
         r_stable  <= '0;
         r_cnt     <= '0;
         r_rise    <= '0;
         r_fall    <= '0;
         r_pend    <= '0;
         r_overrun <= '0;
         r_mem     <= '0;
         r_wr_ptr  <= '0;
         r_rd_ptr  <= '0;
         r_count   <= '0;
      end else begin
         r_sync    <= {r_sync[SYNC_STAGES-2:0], pad_c_i};
         r_stable  <= w_stable_d;
         r_cnt     <= w_cnt_d;
         r_rise    <= w_stable_d & ~r_stable;
         r_fall    <= ~w_stable_d & r_stable;
         r_pend    <= w_pend_d;
         r_overrun <= w_overrun_d;
         r_count   <= w_count_d;
         if (w_push) begin
            r_mem[r_wr_ptr] <= {w_push_idx, r_stable[w_push_idx]};
            r_wr_ptr        <= r_wr_ptr + 1'b1;
         end
         if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   assign gpio_in_o       = r_stable;
   assign rise_o          = r_rise;
   assign fall_o          = r_fall;
   assign overrun_o       = r_overrun;
   assign evt.evt_valid_o = (r_count != '0);
   assign evt.evt_idx_o   = evt.evt_valid_o ? r_mem[r_rd_ptr][IDX_W:1] : '0;
   assign evt.evt_level_o = evt.evt_valid_o & r_mem[r_rd_ptr][0];
endmodule

// File: tb/tb_gpio_pad_input_filter.sv
// Bench for gpio_pad_input_filter: directed scenarios plus random traffic against a
// behavioural model (sample history, run lengths, event queue).
module tb_gpio_pad_input_filter;
   localparam int NG    = 9;
   localparam int SYNC  = 2;
   localparam int DEPTH = 4;
   localparam int IW    = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [NG-1:0] pad_c, ie, fen, gpio_in, rise, fall, ovr;
   logic [7:0]    flen;
   logic          clr;

   gpio_pad_input_filter_if #(.IDX_W(IW)) evt_if ();

   gpio_pad_input_filter #(
      .NUM_GPIO(NG), .SYNC_STAGES(SYNC), .CNT_WIDTH(8), .FIFO_DEPTH(DEPTH), .IDX_W(IW)
   ) dut (
      .clk(clk), .rst_n(rst_n), .pad_c_i(pad_c), .ie_i(ie), .filt_en_i(fen),
      .filt_len_i(flen), .gpio_in_o(gpio_in), .rise_o(rise), .fall_o(fall),
      .overrun_o(ovr), .clr_overrun_i(clr), .evt(evt_if.master)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_err    = 0;
   bit chk_en   = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   // Model state mirrors what the outputs should show during the current cycle.
   logic [NG-1:0] pad_hist[$];
   logic [NG-1:0] m_stable, m_rise, m_fall, m_pend, m_ovr;
   int            m_run[NG];
   int            m_fifo[$];
   logic [NG-1:0] m_s, m_ns, m_edg, m_pushed;
   int            m_pi;
   bit            m_space;

   always @(posedge clk) begin
      if (!rst_n) begin
         pad_hist.delete();
         m_fifo.delete();
         m_stable = '0; m_rise = '0; m_fall = '0; m_pend = '0; m_ovr = '0;
         foreach (m_run[i]) m_run[i] = 0;
      end else begin
         m_s = (pad_hist.size() >= SYNC) ? pad_hist[SYNC-1] : '0;
         pad_hist.push_front(pad_c);
         if (pad_hist.size() > SYNC) void'(pad_hist.pop_back());
         m_ns = m_stable;
         for (int i = 0; i < NG; i++) begin
            if (ie[i]) begin
               if (!fen[i]) begin
                  m_ns[i] = m_s[i]; m_run[i] = 0;
               end else if (m_s[i] == m_stable[i]) begin
                  m_run[i] = 0;
               end else begin
                  m_run[i]++;
                  if (m_run[i] > int'(flen)) begin m_ns[i] = m_s[i]; m_run[i] = 0; end
               end
            end
         end
         m_edg    = m_rise | m_fall;
         m_pushed = '0;
         m_pi     = -1;
         for (int i = 0; i < NG; i++) if (m_pend[i]) begin m_pi = i; break; end
         m_space = (m_fifo.size() < DEPTH);
         if (m_fifo.size() > 0 && evt_if.evt_ready_i) void'(m_fifo.pop_front());
         if (m_pi >= 0 && m_space) begin
            m_fifo.push_back(m_pi * 2 + int'(m_stable[m_pi]));
            m_pushed[m_pi] = 1'b1;
         end
         m_ovr    = (clr ? '0 : m_ovr) | (m_edg & m_pend & ~m_pushed);
         m_pend   = (m_pend & ~m_pushed) | m_edg;
         m_rise   = m_ns & ~m_stable;
         m_fall   = ~m_ns & m_stable;
         m_stable = m_ns;
      end
   end

   always @(negedge clk) begin
      if (chk_en) begin
         check("gpio_in_o", gpio_in, m_stable);
         check("rise_o", rise, m_rise);
         check("fall_o", fall, m_fall);
         check("overrun_o", ovr, m_ovr);
         check("evt_valid_o", evt_if.evt_valid_o, m_fifo.size() != 0);
         if (m_fifo.size() != 0)
            check("evt_head", evt_if.evt_idx_o * 2 + evt_if.evt_level_o, m_fifo[0]);
      end
   end

   int obs[$];
   int exp_q[$];

   always @(negedge clk)
      if (rst_n && evt_if.evt_valid_o && evt_if.evt_ready_i)
         obs.push_back(int'(evt_if.evt_idx_o) * 2 + int'(evt_if.evt_level_o));

   task automatic tick(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic check_obs(input string name);
      check({name, "_count"}, obs.size(), exp_q.size());
      for (int i = 0; i < exp_q.size(); i++)
         if (i < obs.size()) check(name, obs[i], exp_q[i]);
   endtask

   int first, rcnt;

   initial begin
      rst_n = 1'b0; pad_c = 9'h1FF; ie = 9'h1FF; fen = '0; flen = 8'd0; clr = 1'b0;
      evt_if.evt_ready_i = 1'b1;
      tick(3);
      chk_en = 1'b1;
      check("rst_gpio", gpio_in, 0);
      check("rst_rise", rise, 0);
      check("rst_fall", fall, 0);
      check("rst_valid", evt_if.evt_valid_o, 0);
      check("rst_idx", evt_if.evt_idx_o, 0);
      check("rst_level", evt_if.evt_level_o, 0);
      check("rst_ovr", ovr, 0);

      // Bypass path: three edges from release to gpio_in_o, then nine events in index order.
      rst_n = 1'b1; obs.delete();
      tick(2);
      check("byp_gpio_early", gpio_in, 9'h000);
      tick(1);
      check("byp_gpio", gpio_in, 9'h1FF);
      check("byp_rise", rise, 9'h1FF);
      tick(1);
      check("byp_rise_once", rise, 9'h000);
      tick(20);
      exp_q.delete();
      for (int i = 0; i < NG; i++) exp_q.push_back(i * 2 + 1);
      check_obs("byp_events");

      // Deglitch on pad 2 with length 5.
      pad_c = '0; tick(30);
      fen = 9'h004; flen = 8'd5; obs.delete();
      pad_c[2] = 1'b1; tick(5); pad_c[2] = 1'b0; tick(20);
      check("glitch_gpio2", gpio_in[2], 0);
      check("glitch_no_evt", obs.size(), 0);
      first = -1; rcnt = 0;
      pad_c[2] = 1'b1;
      for (int k = 1; k <= 25; k++) begin
         tick(1);
         if (gpio_in[2] && first < 0) first = k;
         if (rise[2]) rcnt++;
         if (k == 6) pad_c[2] = 1'b0;
      end
      check("filt_latency", first, 8);
      check("filt_rise_count", rcnt, 1);
      exp_q = '{5, 4};
      check_obs("filt_events");
      fen = '0; flen = 8'd0;

      // Input disable on pad 4.
      obs.delete(); ie[4] = 1'b0;
      pad_c[4] = 1'b1; tick(10); pad_c[4] = 1'b0; tick(10); pad_c[4] = 1'b1; tick(10);
      check("ie_hold_gpio4", gpio_in[4], 0);
      check("ie_no_evt", obs.size(), 0);
      ie[4] = 1'b1; tick(1);
      check("ie_rise4", rise, 9'h010);
      tick(5);
      exp_q = '{9};
      check_obs("ie_events");
      pad_c[4] = 1'b0; tick(10);

      // Backpressure and overrun.
      obs.delete(); evt_if.evt_ready_i = 1'b0;
      pad_c[3:0] = 4'hF; tick(10);
      pad_c[5] = 1'b1; tick(10); pad_c[5] = 1'b0; tick(10);
      check("ovr_set", ovr, 9'h020);
      evt_if.evt_ready_i = 1'b1; tick(15);
      exp_q = '{1, 3, 5, 7, 10};
      check_obs("ovr_events");
      clr = 1'b1; tick(1); clr = 1'b0;
      check("ovr_clear", ovr, 9'h000);

      // Full FIFO: one pop, push of the pending bit lands the cycle after.
      obs.delete(); evt_if.evt_ready_i = 1'b0;
      pad_c[3:0] = 4'h0; tick(10);
      pad_c[6] = 1'b1; tick(10);
      evt_if.evt_ready_i = 1'b1; tick(1); evt_if.evt_ready_i = 1'b0;
      check("full_valid_after_pop", evt_if.evt_valid_o, 1);
      tick(5);
      check("full_one_pop", obs.size(), 1);
      evt_if.evt_ready_i = 1'b1; tick(10);
      exp_q = '{0, 2, 4, 6, 13};
      check_obs("full_events");

      // Mid-operation reset with events queued.
      evt_if.evt_ready_i = 1'b0;
      pad_c[2:0] = 3'h7; tick(10);
      rst_n = 1'b0; tick(1);
      check("mid_rst_valid", evt_if.evt_valid_o, 0);
      check("mid_rst_gpio", gpio_in, 0);
      rst_n = 1'b1; obs.delete();
      tick(2);
      check("mid_rst_rise_early", rise, 9'h000);
      tick(1);
      check("mid_rst_rise", rise, 9'h047);
      evt_if.evt_ready_i = 1'b1; tick(15);
      exp_q = '{1, 3, 5, 13};
      check_obs("mid_rst_events");

      // Random traffic against the model.
      obs.delete();
      for (int c = 0; c < 4000; c++) begin
         int rate;
         rate = (((c / 200) % 3) == 0) ? 3 : ((((c / 200) % 3) == 1) ? 15 : 63);
         for (int b = 0; b < NG; b++) if ($urandom_range(rate) == 0) pad_c[b] = ~pad_c[b];
         if ($urandom_range(63) == 0) ie = 9'($urandom) | 9'($urandom);
         if ($urandom_range(63) == 0) fen = 9'($urandom);
         if ($urandom_range(63) == 0) flen = 8'($urandom_range(6));
         evt_if.evt_ready_i = ($urandom_range(9) < 6);
         clr   = ($urandom_range(19) == 0);
         rst_n = ($urandom_range(499) != 0);
         tick(1);
      end
      rst_n = 1'b1; clr = 1'b0;
      tick(2);
      $display("CHECKS %0d ERRORS %0d", n_checks, n_err);
      $finish;
   end
endmodule
